stack_catcher: RTL and testbench
================================

# stack_catcher

Consumer end of the falling-item interface: samples the falling item's position every `fall_clk` tick and compares it with the player's stack. It raises a one-tick `collision` pulse on a catch, which makes the item generator respawn the item. It also counts misses and maintains stack height, score, lives and game-over status. It sits between the item generator, the player-position logic and the VGA/score display.

## Interface
- `PLAYER_W`, 60: player/stack width in pixels.
- `ITEM_W`, 20: item width and height in pixels.
- `BLOCK_H`, 20: height added to the stack per caught item.
- `BASE_Y`, 400: y of the stack top when the stack is empty.
- `MISS_Y`, 400: item_y at or above which an uncaught item counts as a miss.
- `MAX_HEIGHT`, 15: stack height at which the tower completes.
- `fall_clk`  in  1  game tick; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pause`  in  1  freezes all state while 1.
- `item_x`  in  10  falling item left x.
- `item_y`  in  10  falling item top y.
- `item_color`  in  2  falling item colour, always 1–3.
- `player_x`  in  10  stack left x.
- `collision`  out  1  registered catch pulse, one `fall_clk` cycle wide.
- `stack_height`  out  4  number of blocks on the stack.
- `top_color`  out  2  colour of the top block; 0 when the stack is empty.
- `score`  out  8  saturating score.
- `lives`  out  2  remaining lives.
- `game_over`  out  1  high in state OVER.

## Operation
- **Derived values**
  - top_y = BASE_Y − stack_height·BLOCK_H, 10-bit; the default parameters guarantee no underflow (minimum 100).
  - Compute item_y + ITEM_W and player_x + PLAYER_W at 11 bits.
  - overlap = (item_x + ITEM_W > player_x) && (item_x < player_x + PLAYER_W).
  - catch = overlap && (item_y + ITEM_W ≥ top_y).
  - miss = !catch && (item_y ≥ MISS_Y).
- **States:** TRACK, HIT, MISS, WAIT_CLEAR, OVER.
- **TRACK:**
  - catch → HIT:
    - Set collision=1.
    - Increment stack_height.
    - Set top_color = item_color.
    - Add 2 to score if item_color equals the old top_color and the stack was non-empty; otherwise add 1. Saturate at 255.
  - miss → MISS, with lives decremented.
  - Otherwise stay in TRACK.
  - catch has priority over miss.
- **HIT:** → WAIT_CLEAR, with collision=0.
  - If stack_height == MAX_HEIGHT: clear the stack (stack_height=0, top_color=0) and add 5 to score, saturating.
- **MISS:** → OVER if lives == 0, else WAIT_CLEAR.
- **WAIT_CLEAR:** → TRACK when item_y == 0, i.e. the item has respawned. This blocks double-counting one item.
- **OVER:**
  - Terminal state; only `rst` leaves it.
  - game_over=1; collision is never asserted; all counters are frozen.
- **pause=1:**
  - FSM and all counters hold.
  - A collision already high still drops on the next edge; HIT completes its exit to WAIT_CLEAR.
  - No new catch or miss is evaluated.
- **Reset values:** state TRACK, collision 0, stack_height 0, top_color 0, score 0, lives 3, game_over 0.

## Timing
- Inputs are sampled at edge N. Catch/miss effects (collision, counters, lives) are visible after edge N.
- collision is high for exactly one cycle, N to N+1. The item generator resets asynchronously on its rising edge, so item_y reads 0 during cycle N+1.
- Catch-to-TRACK: minimum 3 edges (TRACK→HIT→WAIT_CLEAR→TRACK).
- Miss-to-TRACK: minimum 3 edges. The generator wraps y≥400 to 0 on its own next tick.
- Tower completion: the clear happens one edge after the catch that reached MAX_HEIGHT. stack_height reads MAX_HEIGHT for exactly one cycle.
- Asynchronous rst mid-HIT drops collision immediately and restores all reset values.
- All outputs come from registers; there are no combinational paths from inputs to outputs.

## Test plan
- **Catch on empty stack.** player_x=100, item_x=110, item_y stepping 0,5,…,380.
  - Required: collision high one cycle after item_y=380 is sampled.
  - Then stack_height=1, top_color=item_color, score=1, then WAIT_CLEAR until item_y=0.
- **Same-colour bonus.** Two consecutive colour-2 catches.
  - Required: score 1 then 3; top_y for the second catch is 380, so the catch fires at item_y=360.
- **Miss.** item_x=300, player_x=0, item_y reaches 400.
  - Required: lives 3→2, no collision, return to TRACK after item_y=0.
- **Game over.** Three misses.
  - Required: lives=0, game_over=1 one edge after the third miss.
  - Further overlapping items produce no collision and score stays constant.
- **Tower complete.** Preload 14 catches, then a 15th catch.
  - Required: stack_height=15 for one cycle, then 0 with top_color=0 and score += 5.
  - Also check the score ceiling saturates at 255.
- **Pause and reset.**
  - Set pause=1 while a catching position is presented. Required: no collision and all outputs held.
  - Assert rst during HIT. Required: collision falls without a clock edge and outputs return to reset values.

Source files
------------

// File: rtl/stack_catcher.sv
// Falling-item catcher: collision pulse, stack height, score, lives.
// Registered outputs, all state on the rising edge of fall_clk.
module stack_catcher #(
  parameter int PLAYER_W   = 60,
  parameter int ITEM_W     = 20,
  parameter int BLOCK_H    = 20,
  parameter int BASE_Y     = 400,
  parameter int MISS_Y     = 400,
  parameter int MAX_HEIGHT = 15
) (
  input  logic       fall_clk,
  input  logic       rst,
  input  logic       pause,
  input  logic [9:0] item_x,
  input  logic [9:0] item_y,
  input  logic [1:0] item_color,
  input  logic [9:0] player_x,
  output logic       collision,
  output logic [3:0] stack_height,
  output logic [1:0] top_color,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over
);

  typedef enum logic [2:0] {
    TRACK, HIT, MISS, WAIT_CLEAR, OVER
  } state_t;

  state_t     state_q, state_d;
  logic       coll_q, coll_d;
  logic [3:0] height_q, height_d;
  logic [1:0] top_q, top_d;
  logic [7:0] score_q, score_d;
  logic [1:0] lives_q, lives_d;

  logic [9:0]  top_y;
  logic [10:0] item_bot, item_rt, pl_rt;
  logic        overlap, catch_w, miss_w;

  assign top_y    = 10'(BASE_Y - int'(height_q) * BLOCK_H);
  assign item_bot = {1'b0, item_y} + 11'(ITEM_W);
  assign item_rt  = {1'b0, item_x} + 11'(ITEM_W);
  assign pl_rt    = {1'b0, player_x} + 11'(PLAYER_W);

  assign overlap = (item_rt > {1'b0, player_x})
                && ({1'b0, item_x} < pl_rt);
  assign catch_w = overlap && (item_bot >= {1'b0, top_y});
  assign miss_w  = !catch_w && (item_y >= 10'(MISS_Y));

  function automatic logic [7:0] sat_add(
    input logic [7:0] a,
    input logic [3:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + {5'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    coll_d   = 1'b0;
    height_d = height_q;
    top_d    = top_q;
    score_d  = score_q;
    lives_d  = lives_q;
    unique case (state_q)
      TRACK: begin
        if (!pause && catch_w) begin
          state_d  = HIT;
          coll_d   = 1'b1;
          height_d = height_q + 4'd1;
          top_d    = item_color;
          if (item_color == top_q && height_q != 4'd0)
            score_d = sat_add(score_q, 4'd2);
          else
            score_d = sat_add(score_q, 4'd1);
        end else if (!pause && miss_w) begin
          state_d = MISS;
          lives_d = lives_q - 2'd1;
        end
      end
      // HIT always finishes, even while paused.
      HIT: begin
        state_d = WAIT_CLEAR;
        if (height_q == 4'(MAX_HEIGHT)) begin
          height_d = 4'd0;
          top_d    = 2'd0;
          score_d  = sat_add(score_q, 4'd5);
        end
      end
      MISS: begin
        if (!pause)
          state_d = (lives_q == 2'd0) ? OVER : WAIT_CLEAR;
      end
      WAIT_CLEAR: begin
        if (!pause && item_y == 10'd0)
          state_d = TRACK;
      end
      OVER: state_d = OVER;
      default: state_d = TRACK;
    endcase
  end

  always_ff @(posedge fall_clk or posedge rst) begin
    if (rst) begin
      state_q  <= TRACK;
      coll_q   <= 1'b0;
      height_q <= 4'd0;
      top_q    <= 2'd0;
      score_q  <= 8'd0;
      lives_q  <= 2'd3;
    end else begin
      state_q  <= state_d;
      coll_q   <= coll_d;
      height_q <= height_d;
      top_q    <= top_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
    end
  end

  assign collision    = coll_q;
  assign stack_height = height_q;
  assign top_color    = top_q;
  assign score        = score_q;
  assign lives        = lives_q;
  assign game_over    = (state_q == OVER);

endmodule

// File: tb/tb_stack_catcher.sv
// Randomized bench for stack_catcher against an item-level game model.
// Each item drop is predicted from the catch/miss geometry rules.
module tb_stack_catcher;

  logic       fall_clk;
  logic       rst;
  logic       pause;
  logic [9:0] item_x;
  logic [9:0] item_y;
  logic [1:0] item_color;
  logic [9:0] player_x;
  logic       collision;
  logic [3:0] stack_height;
  logic [1:0] top_color;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;

  int checks;
  int errors;

  int m_h, m_top, m_score, m_lives;
  bit m_over;

  stack_catcher dut (
    .fall_clk    (fall_clk),
    .rst         (rst),
    .pause       (pause),
    .item_x      (item_x),
    .item_y      (item_y),
    .item_color  (item_color),
    .player_x    (player_x),
    .collision   (collision),
    .stack_height(stack_height),
    .top_color   (top_color),
    .score       (score),
    .lives       (lives),
    .game_over   (game_over)
  );

  initial fall_clk = 1'b0;
  always #5 fall_clk = ~fall_clk;

  task automatic tick();
    @(posedge fall_clk);
    #1;
  endtask

  task automatic model_reset();
    m_h = 0; m_top = 0; m_score = 0;
    m_lives = 3; m_over = 0;
  endtask

  task automatic do_reset();
    @(negedge fall_clk);
    pause = 0; item_y = 0; item_x = 0;
    player_x = 0; item_color = 1;
    rst = 1;
    #2;
    rst = 0;
    model_reset();
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Drop one item from y=start in steps of stp until caught or missed,
  // then hold it at y=390 for `hold` edges before the respawn (y=0).
  task automatic drop_item(input int ix, input int px, input int col,
                           input int start, input int stp,
                           input int hold);
    int  y, top;
    bit  ov, c, m, done;
    item_x = 10'(ix);
    player_x = 10'(px);
    item_color = 2'(col);
    ov = (ix + 20 > px) && (ix < px + 60);
    y = start;
    done = 0;
    c = 0;
    m = 0;
    while (!done) begin
      top = 400 - m_h * 20;
      item_y = 10'(y);
      tick();
      c = !m_over && ov && (y + 20 >= top);
      m = !m_over && !c && (y >= 400);
      checks++;
      if (collision !== c) begin
        errors++;
        $display("FAIL coll_y%0d got %0b want %0b", y, collision, c);
      end
      if (c) begin
        m_score = sat(m_score + ((col == m_top && m_h != 0) ? 2 : 1));
        m_h++;
        m_top = col;
      end
      if (m) m_lives--;
      checks++;
      if (stack_height !== 4'(m_h) || top_color !== 2'(m_top) ||
          score !== 8'(m_score) || lives !== 2'(m_lives)) begin
        errors++;
        $display("FAIL evt_y%0d got h%0d t%0d s%0d l%0d want h%0d t%0d s%0d l%0d",
                 y, stack_height, top_color, score, lives,
                 m_h, m_top, m_score, m_lives);
      end
      if (c || m || y >= 400) done = 1;
      else y += stp;
    end
    item_y = (hold > 0) ? 10'd390 : 10'd0;
    tick();
    if (c && m_h == 15) begin
      m_h = 0; m_top = 0; m_score = sat(m_score + 5);
    end
    if (m && m_lives == 0) m_over = 1;
    checks++;
    if (collision !== 1'b0 || stack_height !== 4'(m_h) ||
        top_color !== 2'(m_top) || score !== 8'(m_score) ||
        game_over !== m_over) begin
      errors++;
      $display("FAIL post got c%0b h%0d t%0d s%0d go%0b want h%0d t%0d s%0d go%0b",
               collision, stack_height, top_color, score, game_over,
               m_h, m_top, m_score, m_over);
    end
    for (int i = 1; i < hold; i++) begin
      tick();
      checks++;
      if (collision !== 1'b0 || stack_height !== 4'(m_h)) begin
        errors++;
        $display("FAIL wait_clear got c%0b h%0d want c0 h%0d",
                 collision, stack_height, m_h);
      end
    end
    item_y = 0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    @(negedge fall_clk);
    rst = 1; pause = 0; item_y = 0; item_x = 0;
    player_x = 0; item_color = 1;
    #1;
    checks++;
    if (collision !== 1'b0 || stack_height !== 4'd0 ||
        top_color !== 2'd0 || score !== 8'd0 ||
        lives !== 2'd3 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL reset got c%0b h%0d t%0d s%0d l%0d go%0b",
               collision, stack_height, top_color, score, lives, game_over);
    end
    rst = 0;
    model_reset();
  endtask

  task automatic test_catch_empty();
    do_reset();
    drop_item(110, 100, $urandom_range(1, 3), 0, 5, 3);
    checks++;
    if (stack_height !== 4'd1 || score !== 8'd1) begin
      errors++;
      $display("FAIL catch_empty got h%0d s%0d want h1 s1",
               stack_height, score);
    end
  endtask

  task automatic test_same_colour();
    do_reset();
    drop_item(110, 100, 2, 0, 5, 0);
    drop_item(110, 100, 2, 0, 5, 0);
    checks++;
    if (score !== 8'd3 || stack_height !== 4'd2) begin
      errors++;
      $display("FAIL same_colour got s%0d h%0d want s3 h2",
               score, stack_height);
    end
  endtask

  task automatic test_miss();
    do_reset();
    drop_item(300, 0, 1, 0, 10, 2);
    checks++;
    if (lives !== 2'd2 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL miss got l%0d go%0b want l2 go0", lives, game_over);
    end
    drop_item(110, 100, 3, 0, 5, 0);
    checks++;
    if (stack_height !== 4'd1) begin
      errors++;
      $display("FAIL miss_then_catch got h%0d want h1", stack_height);
    end
  endtask

  task automatic test_game_over();
    do_reset();
    drop_item(110, 100, 1, 0, 5, 0);
    for (int i = 0; i < 3; i++)
      drop_item(300, 0, 2, 0, 20, 0);
    checks++;
    if (lives !== 2'd0 || game_over !== 1'b1) begin
      errors++;
      $display("FAIL game_over got l%0d go%0b want l0 go1",
               lives, game_over);
    end
    drop_item(110, 100, 1, 0, 5, 0);
    drop_item(110, 100, 1, 360, 5, 0);
    checks++;
    if (score !== 8'd1 || stack_height !== 4'd1) begin
      errors++;
      $display("FAIL over_frozen got s%0d h%0d want s1 h1",
               score, stack_height);
    end
  endtask

  task automatic test_tower();
    do_reset();
    for (int i = 0; i < 15; i++)
      drop_item(110, 100, $urandom_range(1, 3), 390, 5, 0);
    checks++;
    if (stack_height !== 4'd0 || top_color !== 2'd0) begin
      errors++;
      $display("FAIL tower got h%0d t%0d want h0 t0",
               stack_height, top_color);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 130; i++)
      drop_item(200, 180, 3, 390, 5, 0);
    checks++;
    if (score !== 8'd255) begin
      errors++;
      $display("FAIL saturate got s%0d want s255", score);
    end
  endtask

  task automatic test_pause();
    do_reset();
    item_x = 110; player_x = 100; item_color = 2;
    item_y = 390; pause = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (collision !== 1'b0 || stack_height !== 4'd0 ||
          score !== 8'd0) begin
        errors++;
        $display("FAIL pause_catch got c%0b h%0d s%0d want c0 h0 s0",
                 collision, stack_height, score);
      end
    end
    item_x = 300; player_x = 0; item_y = 400;
    tick();
    checks++;
    if (lives !== 2'd3) begin
      errors++;
      $display("FAIL pause_miss got l%0d want l3", lives);
    end
    item_y = 0; pause = 0;
    tick();
    item_x = 110; player_x = 100; item_y = 390;
    tick();
    m_h = 1; m_top = 2; m_score = 1;
    checks++;
    if (collision !== 1'b1 || stack_height !== 4'd1) begin
      errors++;
      $display("FAIL unpause_catch got c%0b h%0d want c1 h1",
               collision, stack_height);
    end
    pause = 1; item_y = 0;
    tick();
    checks++;
    if (collision !== 1'b0) begin
      errors++;
      $display("FAIL pause_drop got c%0b want c0", collision);
    end
    item_y = 390;
    tick();
    tick();
    checks++;
    if (collision !== 1'b0 || stack_height !== 4'd1 || score !== 8'd1) begin
      errors++;
      $display("FAIL pause_hold got c%0b h%0d s%0d want c0 h1 s1",
               collision, stack_height, score);
    end
    pause = 0; item_y = 0;
    tick();
    tick();
    drop_item(110, 100, 2, 0, 5, 0);
    checks++;
    if (score !== 8'd3) begin
      errors++;
      $display("FAIL pause_resume got s%0d want s3", score);
    end
  endtask

  task automatic test_rst_mid_hit();
    do_reset();
    drop_item(110, 100, 1, 0, 5, 0);
    item_x = 110; player_x = 100; item_color = 3; item_y = 390;
    tick();
    checks++;
    if (collision !== 1'b1) begin
      errors++;
      $display("FAIL hit_before_rst got c%0b want c1", collision);
    end
    #2;
    rst = 1;
    #1;
    checks++;
    if (collision !== 1'b0 || stack_height !== 4'd0 ||
        top_color !== 2'd0 || score !== 8'd0 ||
        lives !== 2'd3 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_hit got c%0b h%0d t%0d s%0d l%0d go%0b",
               collision, stack_height, top_color, score, lives, game_over);
    end
    item_y = 0;
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_random();
    int px, ix;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      px = $urandom_range(0, 500);
      if ($urandom_range(0, 5) == 0)
        ix = (px + 300) % 560;
      else begin
        ix = px + $urandom_range(0, 79) - 20;
        if (ix < 0) ix = 0;
      end
      drop_item(ix, px, $urandom_range(1, 3), 0,
                $urandom_range(1, 25), $urandom_range(0, 2));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1; pause = 0; item_x = 0; item_y = 0;
    item_color = 1; player_x = 0;
    model_reset();
    test_reset();
    test_catch_empty();
    test_same_colour();
    test_miss();
    test_pause();
    test_tower();
    test_saturate();
    test_random();
    test_game_over();
    test_rst_mid_hit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
